core_avl_bus_arbiter: RTL and testbench
=======================================

Name: core_avl_bus_arbiter

Overview:
- Shares one Avalon-MM master port between two requesters: m0 = instruction fetch (read only) and m1 = load/store unit (read/write, may issue two back-to-back word commands for a misaligned access).
- Zero-latency command multiplexing; grant held across stalls and LSU lock.
- In-order read-response routing via an owner-ID FIFO.
- Sits between the core pipeline and the bus interconnect/cache.

Parameters:
- OUTSTANDING, 4, maximum accepted-but-unanswered reads. Power of 2, >= 2.
- AW, 32, address width.
- DW, 32, data width. Byte-enable width is DW/8.

Ports:
- clk  in  1  clock
- rest  in  1  reset, synchronous, active-high
- m0_address  in  AW  IFU address
- m0_read  in  1  IFU read request
- m0_request_ready  out  1  IFU command accepted this cycle
- m0_read_data  out  DW  IFU read data
- m0_read_data_valid  out  1  IFU read data valid
- m1_address  in  AW  LSU address
- m1_read  in  1  LSU read request
- m1_write  in  1  LSU write request
- m1_byte_en  in  DW/8  LSU byte enables
- m1_write_data  in  DW  LSU write data
- m1_lock  in  1  LSU holds grant (multi-command access)
- m1_request_ready  out  1  LSU command accepted this cycle
- m1_read_data  out  DW  LSU read data
- m1_read_data_valid  out  1  LSU read data valid
- avl_address  out  AW  bus address
- avl_read  out  1  bus read
- avl_write  out  1  bus write
- avl_byte_en  out  DW/8  bus byte enables; all ones for m0
- avl_write_data  out  DW  bus write data
- avl_request_ready  in  1  bus accepted command
- avl_read_data  in  DW  bus read data
- avl_read_data_valid  in  1  bus read data valid
- err_unexpected_rsp  out  1  sticky: read_data_valid arrived with FIFO empty

Behaviour:
- Reset: while rest=1 and in the cycle after it falls, state is reset.
  - grant=0, last_served=0, FIFO empty (count=0), err_unexpected_rsp=0.
  - All request/valid outputs are forced 0 while rest=1.
  - Reset mid-operation discards all pending responses. Later stray valids set the error flag.
- Requests: req0=m0_read; req1=m1_read|m1_write.
- Registered state: grant (owner of the command path), held (1 = grant frozen).
- held is set at the clock edge when either:
  - the granted master requested and avl_request_ready=0 (a command must stay stable), or
  - grant=1 and m1_lock=1.
- held clears otherwise.
- When held=0, the effective grant is chosen combinationally this cycle:
  - only req0 -> 0; only req1 -> 1; neither -> keep grant.
  - both -> fixed priority to m1 (see Optional Feature).
- Command path is combinational from the effective grant (zero cycles):
  - avl_address, avl_byte_en and avl_write_data come from the granted master; m0 byte_en = all ones.
  - avl_read = granted read & !fifo_full.
  - avl_write = granted write. Writes never enter the FIFO.
- Full gating uses fifo_full only; a simultaneous pop does not free a slot in the same cycle.
- mX_request_ready = (grant==X) & avl_request_ready & (avl_read|avl_write). The non-granted master sees 0.
- Owner FIFO, OUTSTANDING x 1 bit, stores the master ID:
  - push on avl_read & avl_request_ready; pop on avl_read_data_valid & !empty.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - Pointers wrap modulo OUTSTANDING. count width is clog2(OUTSTANDING)+1.
- Response routing:
  - mX_read_data = avl_read_data (broadcast).
  - mX_read_data_valid = avl_read_data_valid & !empty & (head==X).
- Error: avl_read_data_valid with the FIFO empty sets err_unexpected_rsp (sticky until rest). Neither valid output asserts.
- Ordering: the bus returns reads in order, so responses reach their owners in issue order. Responses are routed correctly even after the grant has switched.

Optional Feature:
- Macro CORE_AVL_ARB_RR_EN.
- Defined: on contention with held=0, grant goes to !last_served. last_served updates to the accepting master's ID on each accepted command.
- Undefined: contention always grants m1; last_served is not implemented.
- Lock, stall-hold and FIFO behaviour are identical in both builds.

Test Plan:
- Contention, stall: m0_read A=0x100 and m1_read A=0x200 in the same cycle; avl_request_ready low 3 cycles, then high.
  - avl_address holds 0x200 for all 4 cycles; m1_request_ready pulses on cycle 4; then m0 is granted.
- LSU lock: m1_lock=1 with two m1 writes to 0x1FC and 0x200 while m0_read is pending.
  - Both writes go out back-to-back before any m0 command.
  - avl_byte_en/avl_write_data follow m1 exactly.
- FIFO full: OUTSTANDING=4, issue 4 m0 reads with no response.
  - 5th request: avl_read=0. One read_data_valid -> next cycle the 5th is accepted.
- Interleaved routing: accept m0, m1, m0 reads; return data 0xA, 0xB, 0xC.
  - m0 gets 0xA, m1 gets 0xB, m0 gets 0xC; the other valid stays 0 each cycle.
- Reset mid-operation: 2 reads outstanding, pulse rest one cycle, then one avl_read_data_valid.
  - No master valid; err_unexpected_rsp=1 until next rest.
- RR (macro defined): m0 and m1 request continuously with ready=1.
  - Grants alternate m1, m0, m1, m0. Without the macro, m1 is granted every cycle.

Source files
------------

// File: rtl/core_avl_bus_arbiter.sv
// core_avl_bus_arbiter: two-master Avalon-MM command arbiter with in-order read-response routing.
// Define CORE_AVL_ARB_RR_EN for round-robin contention; otherwise the LSU (m1) wins contention.
module core_avl_bus_arbiter #(
   parameter int OUTSTANDING = 4,
   parameter int AW          = 32,
   parameter int DW          = 32
) (
   input  logic            clk,
   input  logic            rest,
   input  logic [AW-1:0]   m0_address,
   input  logic            m0_read,
   output logic            m0_request_ready,
   output logic [DW-1:0]   m0_read_data,
   output logic            m0_read_data_valid,
   input  logic [AW-1:0]   m1_address,
   input  logic            m1_read,
   input  logic            m1_write,
   input  logic [DW/8-1:0] m1_byte_en,
   input  logic [DW-1:0]   m1_write_data,
   input  logic            m1_lock,
   output logic            m1_request_ready,
   output logic [DW-1:0]   m1_read_data,
   output logic            m1_read_data_valid,
   output logic [AW-1:0]   avl_address,
   output logic            avl_read,
   output logic            avl_write,
   output logic [DW/8-1:0] avl_byte_en,
   output logic [DW-1:0]   avl_write_data,
   input  logic            avl_request_ready,
   input  logic [DW-1:0]   avl_read_data,
   input  logic            avl_read_data_valid,
   output logic            err_unexpected_rsp
);
   localparam int PW = $clog2(OUTSTANDING);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);

   logic                   grant_q, grant_d;
   logic                   held_q, held_d;
   logic                   err_q, err_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic [OUTSTANDING-1:0] owner_q;

   logic req0, req1, eff_grant, gnt_req, gnt_rd, gnt_wr;
   logic fifo_full, fifo_empty, push, pop, head, cmd_acc;
`ifdef CORE_AVL_ARB_RR_EN
   logic last_q, last_d;
`endif

   // Effective grant: frozen while held, otherwise picked from this cycle's requests.
   always_comb begin
      req0      = m0_read;
      req1      = m1_read | m1_write;
      eff_grant = grant_q;
      if (!held_q) begin
         if (req0 && req1)
`ifdef CORE_AVL_ARB_RR_EN
            eff_grant = ~last_q;
`else
            eff_grant = 1'b1;
`endif
         else if (req1)
            eff_grant = 1'b1;
         else if (req0)
            eff_grant = 1'b0;
      end
   end

   always_comb begin
      fifo_full  = (count_q == FULL_CNT);
      fifo_empty = (count_q == '0);
      if (eff_grant) begin
         avl_address    = m1_address;
         avl_byte_en    = m1_byte_en;
         avl_write_data = m1_write_data;
         gnt_rd         = m1_read;
         gnt_wr         = m1_write;
         gnt_req        = req1;
      end else begin
         avl_address    = m0_address;
         avl_byte_en    = '1;
         avl_write_data = '0;
         gnt_rd         = m0_read;
         gnt_wr         = 1'b0;
         gnt_req        = req0;
      end
      // Full gating ignores a same-cycle pop so the read path never depends on the response path.
      avl_read         = gnt_rd & ~fifo_full & ~rest;
      avl_write        = gnt_wr & ~rest;
      cmd_acc          = avl_request_ready & (avl_read | avl_write);
      m0_request_ready = ~eff_grant & cmd_acc;
      m1_request_ready = eff_grant & cmd_acc;

      push = avl_read & avl_request_ready;
      pop  = avl_read_data_valid & ~fifo_empty & ~rest;
      head = owner_q[rd_ptr_q];
      m0_read_data       = avl_read_data;
      m1_read_data       = avl_read_data;
      m0_read_data_valid = pop & ~head;
      m1_read_data_valid = pop & head;
      err_unexpected_rsp = err_q;
   end

   always_comb begin
      held_d   = (gnt_req & ~avl_request_ready) | (eff_grant & m1_lock);
      grant_d  = eff_grant;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      err_d    = err_q | (avl_read_data_valid & fifo_empty);
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         grant_q  <= 1'b0;
         held_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         grant_q  <= grant_d;
         held_q   <= held_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   // Owner IDs carry no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push)
         owner_q[wr_ptr_q] <= eff_grant;
   end

`ifdef CORE_AVL_ARB_RR_EN
   always_comb last_d = cmd_acc ? eff_grant : last_q;

   always_ff @(posedge clk) begin
      if (rest)
         last_q <= 1'b0;
      else
         last_q <= last_d;
   end
`endif

endmodule

// File: tb/tb_core_avl_bus_arbiter.sv
// Testbench for core_avl_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model (owner queue, ownership/freeze rules). Honors CORE_AVL_ARB_RR_EN.
module tb_core_avl_bus_arbiter;
   localparam int OUTSTANDING = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
`ifdef CORE_AVL_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rest;
   logic [AW-1:0] m0_address, m1_address, avl_address;
   logic m0_read, m0_request_ready, m0_read_data_valid;
   logic [DW-1:0] m0_read_data, m1_read_data, m1_write_data, avl_write_data, avl_read_data;
   logic m1_read, m1_write, m1_lock, m1_request_ready, m1_read_data_valid;
   logic [BW-1:0] m1_byte_en, avl_byte_en;
   logic avl_read, avl_write, avl_request_ready, avl_read_data_valid, err_unexpected_rsp;

   always #5 clk = ~clk;

   core_avl_bus_arbiter #(.OUTSTANDING(OUTSTANDING), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rest(rest),
      .m0_address(m0_address), .m0_read(m0_read), .m0_request_ready(m0_request_ready),
      .m0_read_data(m0_read_data), .m0_read_data_valid(m0_read_data_valid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byte_en(m1_byte_en), .m1_write_data(m1_write_data), .m1_lock(m1_lock),
      .m1_request_ready(m1_request_ready), .m1_read_data(m1_read_data),
      .m1_read_data_valid(m1_read_data_valid),
      .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
      .avl_byte_en(avl_byte_en), .avl_write_data(avl_write_data),
      .avl_request_ready(avl_request_ready), .avl_read_data(avl_read_data),
      .avl_read_data_valid(avl_read_data_valid), .err_unexpected_rsp(err_unexpected_rsp)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: who owns the bus, whether ownership is frozen, and the queue of read owners.
   bit m_owner, m_frozen, m_last, m_err;
   bit q[$];
   bit who, exp_rd, exp_wr, exp_acc, r0, r1;

   task automatic model_check();
      if (rest) begin
         chk("rst_avl_read", avl_read, 0);
         chk("rst_avl_write", avl_write, 0);
         chk("rst_m0_rdy", m0_request_ready, 0);
         chk("rst_m1_rdy", m1_request_ready, 0);
         chk("rst_m0_vld", m0_read_data_valid, 0);
         chk("rst_m1_vld", m1_read_data_valid, 0);
         return;
      end
      r0 = m0_read;
      r1 = m1_read | m1_write;
      if (m_frozen)       who = m_owner;
      else if (r0 && r1)  who = RR ? !m_last : 1'b1;
      else if (r1)        who = 1'b1;
      else if (r0)        who = 1'b0;
      else                who = m_owner;
      exp_rd  = (who ? m1_read : m0_read) && (q.size() < OUTSTANDING);
      exp_wr  = who && m1_write;
      exp_acc = avl_request_ready && (exp_rd || exp_wr);
      chk("mdl_avl_read", avl_read, exp_rd);
      chk("mdl_avl_write", avl_write, exp_wr);
      chk("mdl_m0_rdy", m0_request_ready, !who && exp_acc);
      chk("mdl_m1_rdy", m1_request_ready, who && exp_acc);
      chk("mdl_addr", avl_address, who ? m1_address : m0_address);
      chk("mdl_be", avl_byte_en, who ? m1_byte_en : {BW{1'b1}});
      if (who) chk("mdl_wdata", avl_write_data, m1_write_data);
      chk("mdl_m0_vld", m0_read_data_valid, avl_read_data_valid && q.size() > 0 && q[0] == 1'b0);
      chk("mdl_m1_vld", m1_read_data_valid, avl_read_data_valid && q.size() > 0 && q[0] == 1'b1);
      if (avl_read_data_valid) begin
         chk("mdl_m0_data", m0_read_data, avl_read_data);
         chk("mdl_m1_data", m1_read_data, avl_read_data);
      end
      chk("mdl_err", err_unexpected_rsp, m_err);
   endtask

   task automatic model_update();
      if (rest) begin
         q.delete();
         m_owner = 0; m_frozen = 0; m_last = 0; m_err = 0;
         return;
      end
      if (avl_read_data_valid) begin
         if (q.size() > 0) void'(q.pop_front());
         else m_err = 1'b1;
      end
      if (exp_rd && avl_request_ready) q.push_back(who);
      if (exp_acc) m_last = who;
      m_frozen = ((who ? r1 : r0) && !avl_request_ready) || (who && m1_lock);
      m_owner  = who;
   endtask

   task automatic half();
      @(negedge clk);
      model_check();
   endtask

   task automatic fin();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic cycle();
      half();
      fin();
   endtask

   task automatic idle();
      m0_read = 0; m1_read = 0; m1_write = 0; m1_lock = 0;
      avl_read_data_valid = 0;
   endtask

   task automatic drain();
      m0_read = 0; m1_read = 0; m1_write = 0; m1_lock = 0;
      for (int i = 0; i < 2 * OUTSTANDING && q.size() > 0; i++) begin
         avl_read_data_valid = 1;
         avl_read_data = $urandom;
         cycle();
      end
      avl_read_data_valid = 0;
   endtask

   initial begin
      rest = 1; m0_address = 0; m1_address = 0; m1_byte_en = 0; m1_write_data = 0;
      avl_read_data = 0; avl_request_ready = 1;
      // Aggressive inputs during reset: nothing may leak through.
      m0_read = 1; m1_write = 1; m1_lock = 1; avl_read_data_valid = 1;
      #1;
      cycle();
      cycle();
      idle();
      rest = 0;
      half();
      chk("post_rst_err", err_unexpected_rsp, 0);
      chk("post_rst_read", avl_read, 0);
      fin();

      // Contention with a 3-cycle stall: m1 wins and is held until accepted.
      m0_read = 1; m0_address = 32'h100;
      m1_read = 1; m1_address = 32'h200; m1_byte_en = 4'hF;
      for (int k = 0; k < 4; k++) begin
         avl_request_ready = (k == 3);
         half();
         chk("stall_addr", avl_address, 32'h200);
         chk("stall_m1_rdy", m1_request_ready, k == 3);
         chk("stall_m0_rdy", m0_request_ready, 0);
         fin();
      end
      m1_read = 0;
      half();
      chk("after_stall_addr", avl_address, 32'h100);
      chk("after_stall_m0_rdy", m0_request_ready, 1);
      fin();
      m0_read = 0;
      avl_read_data_valid = 1; avl_read_data = 32'h11;
      half();
      chk("stall_rsp_m1", m1_read_data_valid, 1);
      fin();
      avl_read_data = 32'h22;
      half();
      chk("stall_rsp_m0", m0_read_data_valid, 1);
      fin();
      avl_read_data_valid = 0;

      // LSU lock: two back-to-back writes before the pending IFU read.
      m0_read = 1; m0_address = 32'h300;
      m1_write = 1; m1_lock = 1; m1_address = 32'h1FC; m1_byte_en = 4'hC; m1_write_data = 32'hDEADBEEF;
      half();
      chk("lock1_addr", avl_address, 32'h1FC);
      chk("lock1_write", avl_write, 1);
      chk("lock1_be", avl_byte_en, 4'hC);
      chk("lock1_wdata", avl_write_data, 32'hDEADBEEF);
      chk("lock1_m0_rdy", m0_request_ready, 0);
      fin();
      m1_lock = 0; m1_address = 32'h200; m1_byte_en = 4'h3; m1_write_data = 32'h12345678;
      half();
      chk("lock2_addr", avl_address, 32'h200);
      chk("lock2_be", avl_byte_en, 4'h3);
      chk("lock2_wdata", avl_write_data, 32'h12345678);
      chk("lock2_m1_rdy", m1_request_ready, 1);
      fin();
      m1_write = 0;
      half();
      chk("lock3_addr", avl_address, 32'h300);
      chk("lock3_be", avl_byte_en, 4'hF);
      chk("lock3_m0_rdy", m0_request_ready, 1);
      fin();
      drain();

      // FIFO full: fifth read blocked until a response has been popped.
      m0_read = 1; m0_address = 32'h600;
      for (int k = 0; k < OUTSTANDING; k++) begin
         half();
         chk("fill_read", avl_read, 1);
         fin();
      end
      half();
      chk("full_read", avl_read, 0);
      chk("full_m0_rdy", m0_request_ready, 0);
      fin();
      avl_read_data_valid = 1; avl_read_data = 32'h77;
      half();
      chk("full_pop_read", avl_read, 0);
      chk("full_pop_vld", m0_read_data_valid, 1);
      fin();
      avl_read_data_valid = 0;
      half();
      chk("refill_read", avl_read, 1);
      chk("refill_m0_rdy", m0_request_ready, 1);
      fin();
      drain();

      // Interleaved routing m0, m1, m0.
      m0_read = 1; m0_address = 32'h10; cycle();
      m0_read = 0; m1_read = 1; m1_address = 32'h20; cycle();
      m1_read = 0; m0_read = 1; m0_address = 32'h30; cycle();
      m0_read = 0;
      avl_read_data_valid = 1; avl_read_data = 32'hA;
      half();
      chk("il_a_m0v", m0_read_data_valid, 1);
      chk("il_a_m1v", m1_read_data_valid, 0);
      chk("il_a_data", m0_read_data, 32'hA);
      fin();
      avl_read_data = 32'hB;
      half();
      chk("il_b_m0v", m0_read_data_valid, 0);
      chk("il_b_m1v", m1_read_data_valid, 1);
      chk("il_b_data", m1_read_data, 32'hB);
      fin();
      avl_read_data = 32'hC;
      half();
      chk("il_c_m0v", m0_read_data_valid, 1);
      chk("il_c_m1v", m1_read_data_valid, 0);
      chk("il_c_data", m0_read_data, 32'hC);
      fin();
      avl_read_data_valid = 0;

      // Reset mid-operation drops outstanding reads; a stray response flags the error.
      m0_read = 1; m0_address = 32'h700; cycle(); cycle();
      m0_read = 0; rest = 1; cycle();
      rest = 0; avl_read_data_valid = 1; avl_read_data = 32'h55;
      half();
      chk("stray_m0v", m0_read_data_valid, 0);
      chk("stray_m1v", m1_read_data_valid, 0);
      fin();
      avl_read_data_valid = 0;
      half(); chk("err_set", err_unexpected_rsp, 1); fin();
      cycle();
      half(); chk("err_sticky", err_unexpected_rsp, 1); fin();
      rest = 1; cycle(); rest = 0;
      half(); chk("err_cleared", err_unexpected_rsp, 0); fin();

      // Continuous contention: alternation with round-robin, m1 always otherwise.
      m0_read = 1; m0_address = 32'h400;
      m1_write = 1; m1_address = 32'h500; m1_byte_en = 4'hF;
      for (int k = 0; k < 4; k++) begin
         half();
         chk("rr_addr", avl_address, (RR && (k % 2 == 1)) ? 32'h400 : 32'h500);
         fin();
      end
      drain();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         int sel;
         rest = ($urandom_range(0, 63) == 0);
         m0_read = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 2);
         m1_read = (sel == 1);
         m1_write = (sel == 2);
         m0_address = $urandom; m1_address = $urandom;
         m1_byte_en = 4'($urandom); m1_write_data = $urandom;
         m1_lock = ($urandom_range(0, 3) == 0);
         avl_request_ready = ($urandom_range(0, 3) != 0);
         avl_read_data_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         avl_read_data = $urandom;
         cycle();
      end
      rest = 0; avl_request_ready = 1;
      drain();
      half(); chk("final_err", err_unexpected_rsp, 0); fin();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
